// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational 64-bit ALU between two requesters
// (0 = pipeline EX stage, 1 = auxiliary unit). Each cycle at most one
// eligible request is granted. Its operands and control code are driven to
// the ALU, and the ALU output is captured into that requester's response
// register.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins contention
//                           and no last-grant state exists (requester 1 may
//                           starve). When undefined, contention is resolved
//                           round-robin.
module alu_share_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err,

    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_cnt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    // True for the ALU control codes the external ALU actually implements.
    function automatic logic f_op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS: f_op_legal = 1'b1;
            default:                                f_op_legal = 1'b0;
        endcase
    endfunction

    // Per-requester views so the response logic can be generated once.
    logic              w_req_valid [2];
    logic              w_rsp_ready [2];
    logic              w_elig      [2];
    logic              w_gnt       [2];

    logic              r_rsp_valid  [2];
    logic [DATA_W-1:0] r_rsp_result [2];
    logic              r_rsp_zero   [2];
    logic              r_rsp_err    [2];

    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [3:0]        w_sel_op;
    logic              w_sel_legal;

    assign w_req_valid[0] = req0_valid;
    assign w_req_valid[1] = req1_valid;
    assign w_rsp_ready[0] = rsp0_ready;
    assign w_rsp_ready[1] = rsp1_ready;

    // A requester may only win if its response slot is free or being drained now.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign w_elig[gi] = w_req_valid[gi] && (!r_rsp_valid[gi] || w_rsp_ready[gi]);
        end
    endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 always wins; no grant while in reset.
    always_comb begin
        w_gnt[0] = !rst && w_elig[0];
        w_gnt[1] = !rst && w_elig[1] && !w_elig[0];
    end
`else
    // r_last_grant: 1 means requester 1 won most recently, so 0 wins next tie.
    logic r_last_grant;

    // Round-robin: on contention the requester that did not win last time wins.
    always_comb begin
        w_gnt[0] = !rst && w_elig[0] && (!w_elig[1] || r_last_grant);
        w_gnt[1] = !rst && w_elig[1] && (!w_elig[0] || !r_last_grant);
    end

    // Remember the last winner; only grants move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt[0]) begin
            r_last_grant <= 1'b0;
        end else if (w_gnt[1]) begin
            r_last_grant <= 1'b1;
        end
    end
`endif

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    // Operand mux: idle drives zeros and a harmless add so the ALU sees no stale data.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = OP_ADD;
        if (w_gnt[1]) begin
            w_sel_a  = req1_a;
            w_sel_b  = req1_b;
            w_sel_op = req1_op;
        end else if (w_gnt[0]) begin
            w_sel_a  = req0_a;
            w_sel_b  = req0_b;
            w_sel_op = req0_op;
        end
    end

    assign w_sel_legal = f_op_legal(w_sel_op);
    assign alu_in1     = w_sel_a;
    assign alu_in2     = w_sel_b;
    assign alu_cnt     = w_sel_legal ? w_sel_op : OP_ADD;

    // Response registers: load on grant (undefined ops flagged), clear on drain.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rsp_valid[gi]  <= 1'b0;
                    r_rsp_result[gi] <= '0;
                    r_rsp_zero[gi]   <= 1'b0;
                    r_rsp_err[gi]    <= 1'b0;
                end else if (w_gnt[gi]) begin
                    r_rsp_valid[gi] <= 1'b1;
                    if (w_sel_legal) begin
                        r_rsp_result[gi] <= alu_result;
                        r_rsp_zero[gi]   <= alu_zero;
                        r_rsp_err[gi]    <= 1'b0;
                    end else begin
                        r_rsp_result[gi] <= '0;
                        r_rsp_zero[gi]   <= 1'b1;
                        r_rsp_err[gi]    <= 1'b1;
                    end
                end else if (w_rsp_ready[gi]) begin
                    r_rsp_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp0_result = r_rsp_result[0];
    assign rsp0_zero   = r_rsp_zero[0];
    assign rsp0_err    = r_rsp_err[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp1_result = r_rsp_result[1];
    assign rsp1_zero   = r_rsp_zero[1];
    assign rsp1_err    = r_rsp_err[1];

endmodule
